// File: rtl/jpeg_block_pkg.sv
// Shared constants for the 64-sample JPEG block datapath: geometry, serializer states
// and the JPEG zigzag scan table used when ZIGZAG_SCAN_EN is defined.
package jpeg_block_pkg;

  localparam int BLK_DEPTH = 64;
  localparam int BLK_IDX_W = 6;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_t;

  localparam logic [5:0] ZIGZAG_LUT [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/block_scan_addr_gen.sv
// Maps a scan position to a buffer address: JPEG zigzag when ZIGZAG_SCAN_EN is
// defined (requires 64-entry blocks), raster identity otherwise.
module block_scan_addr_gen
  import jpeg_block_pkg::*;
#(
  parameter int IDX_W = BLK_IDX_W
) (
  input  logic [IDX_W-1:0] i_cnt,
  output logic [IDX_W-1:0] o_addr
);

`ifdef ZIGZAG_SCAN_EN
  assign o_addr = ZIGZAG_LUT[i_cnt];
`else
  assign o_addr = i_cnt;
`endif

endmodule

// File: rtl/block_serializer_64x8bit.sv
// Captures one parallel 64-sample block and streams it out one sample per transfer
// over valid/ready. Scan order is zigzag when ZIGZAG_SCAN_EN is defined, raster otherwise.
module block_serializer_64x8bit
  import jpeg_block_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = BLK_DEPTH,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  block_valid,
  output logic                  block_ready,
  input  logic [DATA_WIDTH-1:0] block_data [0:DEPTH-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(DEPTH - 1);

  ser_state_t            r_state;
  logic [IDX_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_buf [0:DEPTH-1];
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [IDX_W-1:0]      r_out_index;
  logic                  r_out_last;

  logic [IDX_W-1:0]      w_next_cnt;
  logic [IDX_W-1:0]      w_next_addr;

  // Scan position the output registers load next: 0 on capture, cnt+1 while streaming.
  always_comb begin
    w_next_cnt = '0;
    if (r_state == STREAM) begin
      w_next_cnt = r_cnt + IDX_W'(1);
    end else begin
      w_next_cnt = '0;
    end
  end

  block_scan_addr_gen #(
    .IDX_W (IDX_W)
  ) u_addr_gen (
    .i_cnt  (w_next_cnt),
    .o_addr (w_next_addr)
  );

  // Outputs are registered one step ahead, so out_ready never reaches out_data combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (block_valid) begin
            r_buf       <= block_data;
            r_cnt       <= '0;
            r_state     <= STREAM;
            r_out_valid <= 1'b1;
            r_out_data  <= block_data[w_next_addr];
            r_out_index <= w_next_addr;
            r_out_last  <= (LAST_CNT == '0);
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (r_cnt == LAST_CNT) begin
              r_state     <= IDLE;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_out_index <= '0;
              r_out_last  <= 1'b0;
            end else begin
              r_cnt       <= w_next_cnt;
              r_out_data  <= r_buf[w_next_addr];
              r_out_index <= w_next_addr;
              r_out_last  <= (w_next_cnt == LAST_CNT);
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
          r_out_index <= '0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign block_ready = (r_state == IDLE);
  assign busy        = (r_state == STREAM);
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_index   = r_out_index;
  assign out_last    = r_out_last;

endmodule

// File: tb/tb_block_serializer_64x8bit.sv
// Scoreboard bench for block_serializer_64x8bit: captures push the block's expected
// sample stream (scan order derived from the zigzag diagonal walk); a monitor pops on transfers.
module tb_block_serializer_64x8bit;

  localparam int DW = 8;
  localparam int D  = 64;
  localparam int IW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          block_valid;
  logic          block_ready;
  logic [DW-1:0] block_data [0:D-1];
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          busy;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   scan [0:D-1];
  int   n_cap = 0;
  int   xfer_cnt = 0;

  logic          prev_reset = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_index;
  logic          prev_last;
  logic          was_idle;

  block_serializer_64x8bit dut (
    .clock       (clock),
    .reset       (reset),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_data  (block_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Scan order from the definition: zigzag walks the 15 anti-diagonals of the 8x8 block.
  function automatic void build_scan();
    int k = 0;
`ifdef ZIGZAG_SCAN_EN
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 8 ? s : 7); r >= 0 && s - r < 8; r--) begin
          scan[k] = r * 8 + (s - r);
          k++;
        end
      end else begin
        for (int r = (s < 8 ? 0 : s - 7); r <= s && r < 8; r++) begin
          scan[k] = r * 8 + (s - r);
          k++;
        end
      end
    end
`else
    for (int i = 0; i < D; i++) begin
      scan[i] = i;
      k++;
    end
`endif
    if (k != D) $display("FAIL scan_build: got %0d expected %0d", k, D);
  endfunction

  // Monitor and predictor: sampled on the falling edge, mid-cycle between active edges.
  always @(negedge clock) begin
    was_idle = (q.size() == 0);
    if (prev_reset) begin
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_index", int'(out_index), 0);
      check("rst_out_last", int'(out_last), 0);
      check("rst_block_ready", int'(block_ready), 1);
      check("rst_busy", int'(busy), 0);
    end
    check("out_valid_vs_model", int'(out_valid), was_idle ? 0 : 1);
    check("busy_vs_model", int'(busy), was_idle ? 0 : 1);
    check("block_ready_vs_model", int'(block_ready), was_idle ? 1 : 0);
    if (prev_stall && !prev_reset) begin
      check("stall_data_hold", int'(out_data), int'(prev_data));
      check("stall_index_hold", int'(out_index), int'(prev_index));
      check("stall_last_hold", int'(out_last), int'(prev_last));
    end
    if (!reset && out_valid && out_ready && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("out_data", int'(out_data), int'(e.data));
      check("out_index", int'(out_index), int'(e.idx));
      check("out_last", int'(out_last), int'(e.last));
      xfer_cnt++;
    end
    if (reset) begin
      q.delete();
    end else if (was_idle && block_valid) begin
      for (int k = 0; k < D; k++) begin
        exp_t e;
        e.data = block_data[scan[k]];
        e.idx  = IW'(scan[k]);
        e.last = (k == D - 1);
        q.push_back(e);
      end
      xfer_cnt = 0;
      n_cap++;
    end
    prev_reset = reset;
    prev_stall = out_valid && !out_ready && !reset;
    prev_data  = out_data;
    prev_index = out_index;
    prev_last  = out_last;
  end

  task automatic set_ready(input int mode, input int c);
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = (c % 4 == 0) || (c % 4 == 3);
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic send_block();
    block_valid = 1'b1;
    @(posedge clock);
    #1 block_valid = 1'b0;
  endtask

  task automatic drain(input int mode);
    bit done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      set_ready(mode, c);
      @(posedge clock);
      #1;
      if (q.size() == 0) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    out_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    build_scan();
    reset = 1'b1;
    block_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < D; i++) block_data[i] = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Ramp data, full throughput.
    for (int i = 0; i < D; i++) block_data[i] = DW'(i);
    out_ready = 1'b1;
    send_block();
    drain(0);

    // Backpressure pattern 1,0,0,1.
    for (int i = 0; i < D; i++) block_data[i] = DW'($urandom);
    send_block();
    drain(1);

    // block_valid held high with changing data: only the post-last capture counts.
    ok = 1'b0;
    block_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < D; i++) block_data[i] = DW'($urandom);
      if (n_cap >= 3 + 2) ok = 1'b1;
    end
    block_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL second_capture: got %0d captures expected 5", n_cap);
    end
    drain(0);

    // Reset mid-stream at sample 20, then a fresh block.
    for (int i = 0; i < D; i++) block_data[i] = DW'($urandom);
    send_block();
    out_ready = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(posedge clock);
      #1;
      if (xfer_cnt >= 20) ok = 1'b1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL reach_sample20: got %0d expected 20", xfer_cnt);
    end
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < D; i++) block_data[i] = DW'($urandom);
    send_block();
    drain(2);

    // Reset and block_valid together: reset wins.
    reset = 1'b1;
    block_valid = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    block_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // Randomized blocks, random backpressure and gaps.
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < D; i++) block_data[i] = DW'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      send_block();
      drain(2);
    end

    repeat (3) @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
